tile_scheduler: RTL

- Sequences one matrix-multiply workload (M x N output, K reduction) onto the PE array.
- Splits the workload into array-sized tiles: NUM_ROWS rows x NUM_PEs_PER_ROW columns x NUM_MACS K-elements.
- Issues one tile command per tile over a valid/ready handshake, then waits for array completion before issuing the next.
- Sits above the array controller; that controller consumes each command and pulses array_done when the tile finishes.

---
 rtl/tile_scheduler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/tile_scheduler.sv
// tile_scheduler: splits an M x N x K matmul workload into array-sized tile commands
// and issues them one at a time, waiting for the array to finish each tile.
module tile_scheduler #(
  parameter int INT8            = 8,
  parameter int NUM_MACS        = 5,
  parameter int NUM_PEs_PER_ROW = 5,
  parameter int NUM_ROWS        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_workLoad,
  input  logic [2*INT8-1:0] M_size,
  input  logic [2*INT8-1:0] N_size,
  input  logic [2*INT8-1:0] K_size,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              size_err,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2*INT8-1:0] row_base,
  output logic [2*INT8-1:0] col_base,
  output logic [2*INT8-1:0] k_base,
  output logic [INT8-1:0]   rows_valid,
  output logic [INT8-1:0]   cols_valid,
  output logic [INT8-1:0]   k_valid,
  output logic              first_k,
  output logic              last_k,
  input  logic              array_done
);
  localparam int W = 2 * INT8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
  state_t state, state_n;
  logic [W-1:0] m_q, n_q, k_q, m_e, n_e, k_e;
  logic [W-1:0] rb_n, cb_n, kb_n, rem_r, rem_c, rem_k;
  logic [W:0] k_sum, c_sum, r_sum;
  logic ld, zero, go, bad, fin_n, upd;
  // A load in the same cycle as start must be visible to that start
  assign ld    = state == IDLE && load_workLoad;
  assign m_e   = ld ? M_size : m_q;
  assign n_e   = ld ? N_size : n_q;
  assign k_e   = ld ? K_size : k_q;
  assign zero  = m_e == '0 || n_e == '0 || k_e == '0;
  assign go    = state == IDLE && start && !zero;
  assign bad   = state == IDLE && start && zero;
  assign k_sum = {1'b0, k_base} + (W+1)'(NUM_MACS);
  assign c_sum = {1'b0, col_base} + (W+1)'(NUM_PEs_PER_ROW);
  assign r_sum = {1'b0, row_base} + (W+1)'(NUM_ROWS);
  always_comb begin
    state_n = state;
    rb_n    = row_base;
    cb_n    = col_base;
    kb_n    = k_base;
    fin_n   = 1'b0;
    case (state)
      IDLE:  if (go) begin
        state_n = ISSUE;
        rb_n    = '0;
        cb_n    = '0;
        kb_n    = '0;
      end
      ISSUE: state_n = cmd_ready ? WAIT : ISSUE;
      WAIT:  if (array_done) begin
        state_n = ISSUE;
        kb_n    = k_sum[W-1:0];
        if (k_sum >= {1'b0, k_q}) begin
          kb_n = '0;
          cb_n = c_sum[W-1:0];
          if (c_sum >= {1'b0, n_q}) begin
            cb_n = '0;
            rb_n = r_sum[W-1:0];
            if (r_sum >= {1'b0, m_q}) begin
              state_n = FIN;
              fin_n   = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
  assign upd   = go || (state == WAIT && array_done && !fin_n);
  assign rem_r = m_e - rb_n;
  assign rem_c = n_e - cb_n;
  assign rem_k = k_e - kb_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m_q        <= '0;
      n_q        <= '0;
      k_q        <= '0;
      done       <= 1'b0;
      size_err   <= 1'b0;
      row_base   <= '0;
      col_base   <= '0;
      k_base     <= '0;
      rows_valid <= '0;
      cols_valid <= '0;
      k_valid    <= '0;
      first_k    <= 1'b0;
      last_k     <= 1'b0;
    end else begin
      state    <= state_n;
      done     <= fin_n || bad;
      size_err <= bad ? 1'b1 : ld ? 1'b0 : size_err;
      if (ld) begin
        m_q <= M_size;
        n_q <= N_size;
        k_q <= K_size;
      end
      if (upd) begin
        row_base   <= rb_n;
        col_base   <= cb_n;
        k_base     <= kb_n;
        rows_valid <= rem_r < W'(NUM_ROWS) ? rem_r[INT8-1:0] : INT8'(NUM_ROWS);
        cols_valid <= rem_c < W'(NUM_PEs_PER_ROW) ? rem_c[INT8-1:0] : INT8'(NUM_PEs_PER_ROW);
        k_valid    <= rem_k < W'(NUM_MACS) ? rem_k[INT8-1:0] : INT8'(NUM_MACS);
        first_k    <= kb_n == '0;
        last_k     <= {1'b0, kb_n} + (W+1)'(NUM_MACS) >= {1'b0, k_e};
      end
    end
  end
  assign busy      = state != IDLE;
  assign cmd_valid = state == ISSUE;
endmodule
